// File: rtl/riscv_seq_alu.sv
// riscv_seq_alu
//   RV32/64-style integer ALU with single-cycle logic/arith/shift/compare ops
//   and an optional multi-cycle radix-2 shift-add multiplier.
//
//   Optional feature macro: RISCV_ALU_MUL_EN
//     defined   -> opcodes 10 (MUL) / 11 (MULHU) run DW cycles through a BUSY state
//     undefined -> opcodes 10/11 are undefined ops (result 0); no FSM, Ready_o = 1
//
//   Parameters
//     DW : datapath width (8, 16, 32, 64)
//     SW : shift-amount width, $clog2(DW)
//
//   Ports
//     Clk_i     in   clock, rising edge
//     Rstn_i    in   asynchronous active-low reset
//     Valid_i   in   operation request
//     Ready_o   out  request can be accepted this cycle
//     Flush_i   in   synchronous abort of in-flight and same-cycle requests
//     AluCtl_i  in   4-bit opcode, sampled on accept
//     A_i, B_i  in   operands, sampled on accept
//     AluOut_o  out  registered result, holds until the next completed op
//     Valid_o   out  one-cycle pulse marking AluOut_o as new
`timescale 1ns/1ps
module riscv_seq_alu #(
  parameter int DW = 32,
  parameter int SW = $clog2(DW)
) (
  input  logic          Clk_i,
  input  logic          Rstn_i,
  input  logic          Valid_i,
  output logic          Ready_o,
  input  logic          Flush_i,
  input  logic [3:0]    AluCtl_i,
  input  logic [DW-1:0] A_i,
  input  logic [DW-1:0] B_i,
  output logic [DW-1:0] AluOut_o,
  output logic          Valid_o
);

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpSll  = 4'd2;
  localparam logic [3:0] OpSlt  = 4'd3;
  localparam logic [3:0] OpSltu = 4'd4;
  localparam logic [3:0] OpXor  = 4'd5;
  localparam logic [3:0] OpSrl  = 4'd6;
  localparam logic [3:0] OpSra  = 4'd7;
  localparam logic [3:0] OpOr   = 4'd8;
  localparam logic [3:0] OpAnd  = 4'd9;

  // Single-cycle result. Multiply opcodes and 12-15 fall to the zero default.
  function automatic logic [DW-1:0] aluResult(input logic [3:0]    op,
                                               input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
    logic signed [DW-1:0] aS;
    logic signed [DW-1:0] bS;
    logic [SW-1:0]        shamt;
    logic [DW-1:0]        r;
    aS    = $signed(a);
    bS    = $signed(b);
    shamt = b[SW-1:0];
    r     = '0;
    case (op)
      OpAdd:   r = a + b;
      OpSub:   r = a - b;
      OpSll:   r = a << shamt;
      OpSlt:   r = {{(DW-1){1'b0}}, (aS < bS)};
      OpSltu:  r = {{(DW-1){1'b0}}, (a < b)};
      OpXor:   r = a ^ b;
      OpSrl:   r = a >> shamt;
      OpSra:   r = aS >>> shamt;
      OpOr:    r = a | b;
      OpAnd:   r = a & b;
      default: r = '0;
    endcase
    return r;
  endfunction

  logic accept;

`ifdef RISCV_ALU_MUL_EN
  localparam logic [3:0] OpMul   = 4'd10;
  localparam logic [3:0] OpMulhu = 4'd11;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} stateT;

  stateT             state;
  stateT             stateNext;
  logic              isMulOp;
  logic              isHigh;
  logic              lastIter;
  logic [SW-1:0]     iterCnt;
  logic [DW-1:0]     mcand;
  // Upper half accumulates partial sums, lower half shifts the multiplier out.
  logic [2*DW-1:0]   prod;
  logic [DW:0]       addSum;
  logic [2*DW-1:0]   prodNext;

  assign isMulOp  = (AluCtl_i == OpMul) || (AluCtl_i == OpMulhu);
  assign Ready_o  = (state == IDLE);
  assign accept   = Valid_i && Ready_o && !Flush_i;
  assign lastIter = (iterCnt == SW'(DW - 1));
  assign addSum   = {1'b0, prod[2*DW-1:DW]} + (prod[0] ? {1'b0, mcand} : {(DW+1){1'b0}});
  assign prodNext = {addSum, prod[DW-1:1]};

  always_ff @(posedge Clk_i or negedge Rstn_i) begin
    if (!Rstn_i) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    if (Flush_i) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept && isMulOp) stateNext = BUSY;
        BUSY:    if (lastIter) stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  // Multiplicand and result-half select are pure data, captured on accept.
  always_ff @(posedge Clk_i) begin
    if (accept && isMulOp) begin
      mcand  <= A_i;
      isHigh <= (AluCtl_i == OpMulhu);
    end
  end

  always_ff @(posedge Clk_i or negedge Rstn_i) begin
    if (!Rstn_i) begin
      AluOut_o <= '0;
      Valid_o  <= 1'b0;
      iterCnt  <= '0;
      prod     <= '0;
    end else begin
      Valid_o <= 1'b0;
      if (accept) begin
        if (isMulOp) begin
          prod    <= {{DW{1'b0}}, B_i};
          iterCnt <= '0;
        end else begin
          AluOut_o <= aluResult(AluCtl_i, A_i, B_i);
          Valid_o  <= 1'b1;
        end
      end else if (state == BUSY && !Flush_i) begin
        prod    <= prodNext;
        iterCnt <= iterCnt + SW'(1);
        // Final step writes straight from the combinational next product.
        if (lastIter) begin
          AluOut_o <= isHigh ? prodNext[2*DW-1:DW] : prodNext[DW-1:0];
          Valid_o  <= 1'b1;
        end
      end
    end
  end
`else
  assign Ready_o = 1'b1;
  assign accept  = Valid_i && !Flush_i;

  always_ff @(posedge Clk_i or negedge Rstn_i) begin
    if (!Rstn_i) begin
      AluOut_o <= '0;
      Valid_o  <= 1'b0;
    end else begin
      Valid_o <= 1'b0;
      if (accept) begin
        AluOut_o <= aluResult(AluCtl_i, A_i, B_i);
        Valid_o  <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_riscv_seq_alu.sv
// tb_riscv_seq_alu
//   Directed bench for riscv_seq_alu with a DW=32 and a DW=8 instance.
//   Expected results are pushed to a per-instance queue with the cycle in which
//   Valid_o must appear; every cycle the observed Valid_o is compared against
//   that schedule and the result word is compared when an entry comes due.
//   Honors RISCV_ALU_MUL_EN the same way as the design.
`timescale 1ns/1ps
module tb_riscv_seq_alu;

`ifdef RISCV_ALU_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  typedef struct {
    logic [63:0] data;
    int          due;
  } expT;

  logic        clk = 1'b0;
  logic        rstn;
  logic        flush;
  logic        valid32, valid8;
  logic [3:0]  op32, op8;
  logic [31:0] a32, b32;
  logic [7:0]  a8, b8;
  logic        ready32, ready8;
  logic        vout32, vout8;
  logic [31:0] out32;
  logic [7:0]  out8;

  expT         q32[$];
  expT         q8[$];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] lastExp32 = '0;
  logic [63:0] lastExp8 = '0;

  always #5 clk = ~clk;

  riscv_seq_alu #(.DW(32)) dut32 (
    .Clk_i(clk), .Rstn_i(rstn), .Valid_i(valid32), .Ready_o(ready32),
    .Flush_i(flush), .AluCtl_i(op32), .A_i(a32), .B_i(b32),
    .AluOut_o(out32), .Valid_o(vout32)
  );

  riscv_seq_alu #(.DW(8)) dut8 (
    .Clk_i(clk), .Rstn_i(rstn), .Valid_i(valid8), .Ready_o(ready8),
    .Flush_i(flush), .AluCtl_i(op8), .A_i(a8), .B_i(b8),
    .AluOut_o(out8), .Valid_o(vout8)
  );

  // Reference ALU, width-generic over 64-bit containers.
  function automatic logic [63:0] model(input int dw, input logic [3:0] op,
                                        input logic [63:0] aIn, input logic [63:0] bIn);
    logic [63:0]  mask, a, b, r, hi;
    logic [127:0] p;
    longint       sa, sb;
    int           sh;
    mask = (dw == 64) ? {64{1'b1}} : ((64'd1 << dw) - 64'd1);
    a    = aIn & mask;
    b    = bIn & mask;
    sh   = int'(b & 64'(dw - 1));
    sa   = a[dw-1] ? longint'(a | ~mask) : longint'(a);
    sb   = b[dw-1] ? longint'(b | ~mask) : longint'(b);
    p    = 128'(a) * 128'(b);
    hi   = 64'(p >> dw);
    case (op)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a << sh;
      4'd3:    r = (sa < sb) ? 64'd1 : 64'd0;
      4'd4:    r = (a < b) ? 64'd1 : 64'd0;
      4'd5:    r = a ^ b;
      4'd6:    r = a >> sh;
      4'd7:    r = 64'(sa >>> sh);
      4'd8:    r = a | b;
      4'd9:    r = a & b;
      4'd10:   r = MulEn ? p[63:0] : 64'd0;
      4'd11:   r = MulEn ? hi : 64'd0;
      default: r = 64'd0;
    endcase
    return r & mask;
  endfunction

  function automatic bit isMul(input logic [3:0] op);
    return MulEn && (op == 4'd10 || op == 4'd11);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    expT e;
    logic expV;
    @(posedge clk);
    cyc++;
    #1;
    expV = (q32.size() != 0) && (q32[0].due == cyc);
    chk("valid32", 64'(vout32), 64'(expV));
    if (expV) begin
      e = q32.pop_front();
      chk("result32", 64'(out32), e.data);
    end
    expV = (q8.size() != 0) && (q8[0].due == cyc);
    chk("valid8", 64'(vout8), 64'(expV));
    if (expV) begin
      e = q8.pop_front();
      chk("result8", 64'(out8), e.data);
    end
  endtask

  task automatic issue32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push);
    expT e;
    valid32 = 1'b1;
    op32    = op;
    a32     = a;
    b32     = b;
    if (push) begin
      e.data    = model(32, op, 64'(a), 64'(b));
      e.due     = cyc + 1 + (isMul(op) ? 32 : 0);
      lastExp32 = e.data;
      q32.push_back(e);
    end
    tick();
    valid32 = 1'b0;
  endtask

  task automatic issue8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    expT e;
    valid8 = 1'b1;
    op8    = op;
    a8     = a;
    b8     = b;
    e.data   = model(8, op, 64'(a), 64'(b));
    e.due    = cyc + 1 + (isMul(op) ? 8 : 0);
    lastExp8 = e.data;
    q8.push_back(e);
    tick();
    valid8 = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; flush = 1'b0;
    valid32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
    valid8 = 1'b0;  op8 = '0;  a8 = '0;  b8 = '0;

    // Reset: asynchronous, visible before any clock edge.
    #3;
    chk("rst_out32", 64'(out32), 64'd0);
    chk("rst_valid32", 64'(vout32), 64'd0);
    chk("rst_ready32", 64'(ready32), 64'd1);
    chk("rst_out8", 64'(out8), 64'd0);
    chk("rst_ready8", 64'(ready8), 64'd1);
    tick();
    tick();
    chk("rst_ready32_held", 64'(ready32), 64'd1);
    rstn = 1'b1;
    tick();

    // Wrap-around add, then the valid pulse must drop.
    issue32(4'd0, 32'hFFFF_FFFF, 32'h1, 1'b1);
    chk("add_wrap", 64'(out32), 64'h0);
    tick();

    issue32(4'd7, 32'h8000_0000, 32'h24, 1'b1);
    chk("sra_shamt_mask", 64'(out32), 64'hF800_0000);
    issue32(4'd3, 32'hFFFF_FFFF, 32'h0, 1'b1);
    chk("slt_neg", 64'(out32), 64'h1);
    issue32(4'd4, 32'hFFFF_FFFF, 32'h0, 1'b1);
    chk("sltu_big", 64'(out32), 64'h0);
    issue32(4'd2, 32'h1, 32'hFFFF_FFFF, 1'b1);
    chk("sll_max", 64'(out32), 64'h8000_0000);
    issue32(4'd6, 32'h8000_0000, 32'h20, 1'b1);
    chk("srl_zero", 64'(out32), 64'h8000_0000);

    // Back-to-back sweep of every opcode that completes in one cycle.
    for (int op = 0; op < 16; op++) begin
      if (isMul(4'(op))) continue;
      issue32(4'(op), $urandom, $urandom, 1'b1);
      chk("ready_single", 64'(ready32), 64'd1);
    end

    // Result holds while idle.
    repeat (3) tick();
    chk("hold_idle", 64'(out32), lastExp32);

    // Flush discards a same-cycle request.
    flush = 1'b1; valid32 = 1'b1; op32 = 4'd0; a32 = 32'd5; b32 = 32'd6;
    tick();
    flush = 1'b0; valid32 = 1'b0;
    chk("flush_idle_hold", 64'(out32), lastExp32);
    tick();

    if (MulEn) begin
      issue32(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      chk("mul_busy_ready", 64'(ready32), 64'd0);
      // Requests while busy are ignored.
      valid32 = 1'b1; op32 = 4'd0; a32 = 32'd1; b32 = 32'd1;
      for (int i = 1; i < 32; i++) begin
        tick();
        chk("mul_busy_ready", 64'(ready32), 64'd0);
      end
      tick();
      valid32 = 1'b0;
      chk("mulhu_ones", 64'(out32), 64'hFFFF_FFFE);
      chk("mul_done_ready", 64'(ready32), 64'd1);

      issue32(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      repeat (32) tick();
      chk("mul_ones", 64'(out32), 64'h1);

      issue32(4'd10, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
      repeat (32) tick();
      issue32(4'd11, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
      repeat (32) tick();

      // Flush at iteration 10 with a competing request.
      issue32(4'd10, 32'd3, 32'd5, 1'b0);
      repeat (10) tick();
      flush = 1'b1; valid32 = 1'b1; op32 = 4'd0; a32 = 32'd1; b32 = 32'd2;
      tick();
      flush = 1'b0; valid32 = 1'b0;
      chk("flush_busy_ready", 64'(ready32), 64'd1);
      chk("flush_busy_hold", 64'(out32), lastExp32);
      repeat (25) tick();
      chk("flush_busy_hold_late", 64'(out32), lastExp32);

      // Reset at iteration 5.
      issue32(4'd10, 32'd7, 32'd9, 1'b0);
      repeat (5) tick();
      rstn = 1'b0;
      #1;
      chk("rst_mid_out", 64'(out32), 64'd0);
      chk("rst_mid_ready", 64'(ready32), 64'd1);
      chk("rst_mid_valid", 64'(vout32), 64'd0);
      tick();
      rstn = 1'b1;
      repeat (35) tick();
      chk("rst_mid_out_after", 64'(out32), 64'd0);
    end else begin
      issue32(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      chk("mul_disabled", 64'(out32), 64'd0);
      chk("mul_disabled_ready", 64'(ready32), 64'd1);
      issue32(4'd0, 32'd9, 32'd9, 1'b1);
      issue32(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      chk("mulhu_disabled", 64'(out32), 64'd0);
      rstn = 1'b0;
      #1;
      chk("rst_run_out", 64'(out32), 64'd0);
      chk("rst_run_ready", 64'(ready32), 64'd1);
      tick();
      rstn = 1'b1;
      tick();
    end
    issue32(4'd0, 32'd3, 32'd4, 1'b1);
    chk("add_after_rst", 64'(out32), 64'd7);

    // DW=8: three consecutive accepts, three consecutive pulses.
    issue8(4'd0, 8'h7F, 8'h01);
    chk("dw8_add", 64'(out8), 64'h80);
    chk("dw8_add_valid", 64'(vout8), 64'd1);
    issue8(4'd1, 8'h00, 8'h01);
    chk("dw8_sub", 64'(out8), 64'hFF);
    chk("dw8_sub_valid", 64'(vout8), 64'd1);
    issue8(4'd15, 8'hAB, 8'hCD);
    chk("dw8_undef", 64'(out8), 64'h00);
    chk("dw8_undef_valid", 64'(vout8), 64'd1);
    tick();
    chk("dw8_valid_drop", 64'(vout8), 64'd0);

    issue8(4'd7, 8'h80, 8'h0B);
    chk("dw8_sra", 64'(out8), 64'hF0);
    for (int op = 0; op < 16; op++) begin
      issue8(4'(op), 8'($urandom), 8'($urandom));
      if (isMul(4'(op))) repeat (8) tick();
    end
    repeat (2) tick();
    chk("dw8_hold", 64'(out8), lastExp8);

    repeat (3) tick();
    chk("drain32", 64'(q32.size()), 64'd0);
    chk("drain8", 64'(q8.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
